pmod_pir_detector: RTL and testbench

Pin-side receiver for the PmodPIR hierarchy. It attaches directly to the Pmod Bridge top and bottom GPIO rows, holds every pin as an input, and conditions the PIR sensor output. Conditioning is synchronisation, debounce, and a retrigger hold-off. The result is a clean motion level, a saturating event count and a sticky interrupt with acknowledge. It takes the place of the AXI GPIO path when motion is to be detected in fabric rather than polled by software.

---
 rtl/pmod_pir_detector.sv | 194 +++++++++++++++++++
 tb/tb_pmod_pir_detector.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_pir_detector.sv
// pmod_pir_detector: PmodPIR pin-side receiver. Holds every Pmod Bridge pin as an
//   input, synchronises and debounces the PIR OUT pin, and counts motion events with a
//   retrigger hold-off, a saturating event counter and a sticky interrupt.
// Latency: pin edge captured after edge k -> motion at k+DEBOUNCE_CYCLES+2 ->
//   event_count/irq at k+DEBOUNCE_CYCLES+3.
// Backpressure: none; the sensor is a level, and irq_ack/count_clear are level controls.
//
// Ports:
//   clk, rst                       sole clock; asynchronous active-high reset
//   gpio_out_top_tri_t/_o/_i       Pmod Bridge top row (t=4'hF, o=4'h0; i[PIR_BIT] = sensor)
//   gpio_out_bottom_tri_t/_o/_i    Pmod Bridge bottom row (t=4'hF, o=4'h0; i unused)
//   enable                         arms event detection; low forces IDLE
//   motion                         debounced sensor level
//   event_count                    saturating count of counted motion events
//   count_clear                    synchronous clear of event_count (a coincident event gives 1)
//   irq, irq_ack                   sticky event interrupt and its clear (set wins)

module pmod_pir_detector #(
  parameter int PIR_BIT         = 0,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES  = 100000000,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [3:0]             gpio_out_top_tri_t,
  output logic [3:0]             gpio_out_top_tri_o,
  input  logic [3:0]             gpio_out_top_tri_i,
  output logic [3:0]             gpio_out_bottom_tri_t,
  output logic [3:0]             gpio_out_bottom_tri_o,
  input  logic [3:0]             gpio_out_bottom_tri_i,
  input  logic                   enable,
  output logic                   motion,
  output logic [COUNT_WIDTH-1:0] event_count,
  input  logic                   count_clear,
  output logic                   irq,
  input  logic                   irq_ack
);

  // Counter widths: the debounce counter only ever holds 0..DEBOUNCE_CYCLES-1 and the
  // hold-off counter only 0..HOLDOFF_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0]        HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pins: receive-only. Tristate enables high, data low, also during reset.
  // ---------------------------------------------------------------------------
  assign gpio_out_top_tri_t    = 4'hF;
  assign gpio_out_top_tri_o    = 4'h0;
  assign gpio_out_bottom_tri_t = 4'hF;
  assign gpio_out_bottom_tri_o = 4'h0;

  // Only one top-row bit carries the sensor; the rest of both rows is ignored.
  logic w_unused_pins;
  assign w_unused_pins = ^{gpio_out_bottom_tri_i, gpio_out_top_tri_i};

  // ---------------------------------------------------------------------------
  // 2-FF synchroniser for the asynchronous sensor pin.
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= gpio_out_top_tri_i[PIR_BIT];
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Debounce: motion follows s only after DEBOUNCE_CYCLES consecutive samples that
  // disagree with it. Any agreeing sample restarts the window. Runs regardless of
  // enable so motion is always a faithful, clean copy of the sensor.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] r_db_cnt;
  logic            r_motion;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_motion <= 1'b0;
    end else if (w_s == r_motion) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_motion <= ~r_motion;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign motion = r_motion;

  // ---------------------------------------------------------------------------
  // Event FSM with retrigger hold-off, event counter and sticky irq.
  // A rise seen in IDLE is a new event; a rise seen in HOLDOFF is the same person
  // still moving and is absorbed without counting.
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [HO_W-1:0]        r_ho_cnt;
  logic                   r_motion_d;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_irq;

  logic w_rise;
  logic w_event;

  assign w_rise  = r_motion & ~r_motion_d;
  // Enable gates counting directly so the cycle enable drops counts nothing, even
  // though the state itself only returns to IDLE at that edge.
  assign w_event = enable & w_rise & (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ho_cnt   <= '0;
      r_motion_d <= 1'b0;
      r_count    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_motion_d <= r_motion;

      if (!enable) begin
        r_state  <= ST_IDLE;
        r_ho_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (!r_motion) begin
              r_state  <= ST_HOLDOFF;
              r_ho_cnt <= HO_LOAD;
            end
          end
          ST_HOLDOFF: begin
            // Rise has priority over expiry, so a rise on the last hold-off cycle
            // is still suppressed.
            if (w_rise) begin
              r_state  <= ST_ACTIVE;
              r_ho_cnt <= '0;
            end else if (r_ho_cnt == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_ho_cnt <= r_ho_cnt - HO_W'(1);
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_ho_cnt <= '0;
          end
        endcase
      end

      // A clear coincident with an event leaves that one event counted.
      if (count_clear) begin
        r_count <= w_event ? CNT_ONE : '0;
      end else if (w_event && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_ONE;
      end

      // Set wins over acknowledge so an event is never lost.
      if (w_event) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign event_count = r_count;
  assign irq         = r_irq;

endmodule

// File: tb/tb_pmod_pir_detector.sv
// tb_pmod_pir_detector: self-checking bench for pmod_pir_detector.
// Directed vectors and sequences with bench-computed expectations, plus a cycle
// scoreboard against a window/timestamp reference model under random stimulus.

module tb_pmod_pir_detector;

  localparam int PIR = 2;
  localparam int DB  = 4;
  localparam int HO  = 10;
  localparam int CW  = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    top_t, top_o, top_i;
  logic [3:0]    bot_t, bot_o, bot_i;
  logic          enable;
  logic          motion;
  logic [CW-1:0] event_count;
  logic          count_clear;
  logic          irq;
  logic          irq_ack;

  pmod_pir_detector #(
    .PIR_BIT        (PIR),
    .DEBOUNCE_CYCLES(DB),
    .HOLDOFF_CYCLES (HO),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .gpio_out_top_tri_t   (top_t),
    .gpio_out_top_tri_o   (top_o),
    .gpio_out_top_tri_i   (top_i),
    .gpio_out_bottom_tri_t(bot_t),
    .gpio_out_bottom_tri_o(bot_o),
    .gpio_out_bottom_tri_i(bot_i),
    .enable               (enable),
    .motion               (motion),
    .event_count          (event_count),
    .count_clear          (count_clear),
    .irq                  (irq),
    .irq_ack              (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic pin;

  // The sensor bit goes on PIR; the other pins carry noise the DUT must ignore.
  task automatic set_pin(input logic v);
    logic [3:0] t;
    t      = 4'($urandom);
    t[PIR] = v;
    pin    = v;
    top_i  = t;
    bot_i  = 4'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model.
  //  - s is the pin as sampled two edges earlier.
  //  - motion flips once the last DB samples of s all disagree with it.
  //  - a rise counts unless it lands within HO edges of the edge at which the
  //    previous burst was seen to end; enable low forgets all history.
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  logic          m_p1, m_s, m_motion, m_motion_d, m_active, m_irq, m_ev;
  logic [CW-1:0] m_count;
  int            m_last_fall;
  logic          m_hist [DB];
  logic          o_motion, o_motion_d, o_s, all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1 = 0; m_s = 0; m_motion = 0; m_motion_d = 0;
      m_active = 0; m_irq = 0; m_count = '0; m_last_fall = -1000;
      for (int i = 0; i < DB; i++) m_hist[i] = 1'b0;
    end else begin
      cyc++;
      o_motion   = m_motion;
      o_motion_d = m_motion_d;
      o_s        = m_s;

      m_ev = 1'b0;
      if (!enable) begin
        m_active    = 1'b0;
        m_last_fall = -1000;
      end else if (o_motion && !o_motion_d) begin
        m_ev     = !m_active && ((cyc - m_last_fall) > HO);
        m_active = 1'b1;
      end else if (m_active && !o_motion) begin
        m_active    = 1'b0;
        m_last_fall = cyc;
      end

      if (count_clear) m_count = m_ev ? CW'(1) : '0;
      else if (m_ev && m_count != {CW{1'b1}}) m_count = m_count + CW'(1);
      if (m_ev) m_irq = 1'b1;
      else if (irq_ack) m_irq = 1'b0;

      for (int i = 0; i < DB - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[DB-1] = o_s;
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++) if (m_hist[i] == o_motion) all_diff = 1'b0;
      if (all_diff) m_motion = !o_motion;
      m_motion_d = o_motion;

      m_s  = m_p1;
      m_p1 = pin;
    end
  end

  logic sb_on = 1'b0;
  always @(negedge clk) begin
    if (sb_on) begin
      chk("sb_motion", 32'(motion), 32'(m_motion));
      chk("sb_count", 32'(event_count), 32'(m_count));
      chk("sb_irq", 32'(irq), 32'(m_irq));
    end
  end

  // Pulse vectors: high length, enable, motion expected to appear, count increment.
  typedef struct {
    int   hi_len;
    logic en;
    logic exp_motion;
    int   exp_inc;
  } vec_t;

  vec_t vt [8];
  int   exp_cnt;
  logic seen;

  initial begin
    vt[0] = '{1, 1'b1, 1'b0, 0};
    vt[1] = '{2, 1'b1, 1'b0, 0};
    vt[2] = '{3, 1'b1, 1'b0, 0};
    vt[3] = '{4, 1'b1, 1'b1, 1};
    vt[4] = '{5, 1'b1, 1'b1, 1};
    vt[5] = '{8, 1'b1, 1'b1, 1};
    vt[6] = '{6, 1'b0, 1'b1, 0};
    vt[7] = '{4, 1'b0, 1'b1, 0};

    // ---- 1. reset with pin high -------------------------------------------------
    rst = 1'b1; enable = 1'b0; irq_ack = 1'b0; count_clear = 1'b0;
    set_pin(1'b1);
    tick(3);
    chk("rst_motion", 32'(motion), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_count", 32'(event_count), 0);
    chk("rst_top_t", 32'(top_t), 32'hF);
    chk("rst_top_o", 32'(top_o), 32'h0);
    chk("rst_bot_t", 32'(bot_t), 32'hF);
    chk("rst_bot_o", 32'(bot_o), 32'h0);
    sb_on = 1'b1;
    rst = 1'b0;
    tick(5);
    chk("post_rst_motion_early", 32'(motion), 0);
    tick(1);
    chk("post_rst_motion_k6", 32'(motion), 1);
    set_pin(1'b0);
    tick(10);
    chk("post_rst_motion_low", 32'(motion), 0);

    // ---- table: glitch rejection and enable gating -------------------------------
    enable = 1'b1; count_clear = 1'b1; tick(1); count_clear = 1'b0;
    tick(30);
    exp_cnt = 0;
    for (int v = 0; v < 8; v++) begin
      enable = vt[v].en;
      seen   = 1'b0;
      set_pin(1'b1);
      for (int c = 0; c < vt[v].hi_len; c++) begin
        tick(1);
        if (motion) seen = 1'b1;
      end
      set_pin(1'b0);
      for (int c = 0; c < 30; c++) begin
        tick(1);
        if (motion) seen = 1'b1;
      end
      enable  = 1'b1;
      exp_cnt = exp_cnt + vt[v].exp_inc;
      chk($sformatf("vec%0d_motion_seen", v), 32'(seen), 32'(vt[v].exp_motion));
      chk($sformatf("vec%0d_count", v), 32'(event_count), 32'(exp_cnt));
      chk($sformatf("vec%0d_motion_end", v), 32'(motion), 0);
    end

    // ---- 2. clean event latency ---------------------------------------------------
    count_clear = 1'b1; irq_ack = 1'b1; tick(1); count_clear = 1'b0; irq_ack = 1'b0;
    chk("clean_pre_irq", 32'(irq), 0);
    set_pin(1'b1);                          // captured first at edge k+1
    tick(5);
    chk("clean_motion_k5", 32'(motion), 0);
    tick(1);
    chk("clean_motion_k6", 32'(motion), 1);
    chk("clean_irq_k6", 32'(irq), 0);
    chk("clean_count_k6", 32'(event_count), 0);
    tick(1);
    chk("clean_irq_k7", 32'(irq), 1);
    chk("clean_count_k7", 32'(event_count), 1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("clean_irq_acked", 32'(irq), 0);

    // ---- 4. retrigger 5 cycles into hold-off, then a rise 12 cycles after -----------
    set_pin(1'b0);
    tick(5);
    set_pin(1'b1);
    tick(7);
    chk("retrig_motion", 32'(motion), 1);
    chk("retrig_count", 32'(event_count), 1);
    chk("retrig_irq", 32'(irq), 0);
    set_pin(1'b0);
    tick(12);
    set_pin(1'b1);
    tick(6);
    chk("late_rise_count_before", 32'(event_count), 1);
    tick(1);
    chk("late_rise_count", 32'(event_count), 2);
    chk("late_rise_irq", 32'(irq), 1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;

    // Hold-off boundary: rise on the last hold-off cycle suppressed, one later counts.
    set_pin(1'b0);
    tick(10);
    set_pin(1'b1);
    tick(7);
    chk("holdoff_last_cycle_count", 32'(event_count), 2);
    chk("holdoff_last_cycle_irq", 32'(irq), 0);
    set_pin(1'b0);
    tick(11);
    set_pin(1'b1);
    tick(7);
    chk("holdoff_expired_count", 32'(event_count), 3);
    chk("holdoff_expired_irq", 32'(irq), 1);

    // ---- 5. saturation -----------------------------------------------------------
    count_clear = 1'b1; tick(1); count_clear = 1'b0;
    chk("sat_cleared", 32'(event_count), 0);
    set_pin(1'b0);
    tick(20);
    for (int e = 0; e < 17; e++) begin
      set_pin(1'b1); tick(8);
      set_pin(1'b0); tick(20);
      chk($sformatf("sat_event%0d", e), 32'(event_count), 32'((e + 1 > 15) ? 15 : e + 1));
    end

    // Event coincident with count_clear.
    set_pin(1'b1); tick(6);
    count_clear = 1'b1; tick(1); count_clear = 1'b0;
    chk("clear_collide_count", 32'(event_count), 1);
    set_pin(1'b0); tick(20);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("ack_clears", 32'(irq), 0);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("ack_idle_noop", 32'(irq), 0);
    // Event coincident with irq_ack: set wins.
    set_pin(1'b1); tick(6);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("ack_collide_irq", 32'(irq), 1);
    chk("ack_collide_count", 32'(event_count), 2);
    set_pin(1'b0); tick(20);

    // ---- 6. enable gating ----------------------------------------------------------
    enable = 1'b0;
    set_pin(1'b1); tick(8);
    chk("dis_motion", 32'(motion), 1);
    chk("dis_count", 32'(event_count), 2);
    enable = 1'b1; tick(5);
    chk("en_while_high_count", 32'(event_count), 2);
    set_pin(1'b0); tick(10);
    set_pin(1'b1); tick(7);
    chk("en_next_rise_count", 32'(event_count), 3);

    // Reset during HOLDOFF: the next rise counts even inside the old hold-off window.
    set_pin(1'b0); tick(8);
    rst = 1'b1; #1;
    chk("rst_ho_motion", 32'(motion), 0);
    chk("rst_ho_count", 32'(event_count), 0);
    chk("rst_ho_irq", 32'(irq), 0);
    tick(1);
    rst = 1'b0;
    set_pin(1'b1);
    tick(6);
    chk("rst_ho_motion_back", 32'(motion), 1);
    chk("rst_ho_count_before", 32'(event_count), 0);
    tick(1);
    chk("rst_ho_next_count", 32'(event_count), 1);
    chk("rst_ho_next_irq", 32'(irq), 1);

    // ---- random stimulus vs model (scoreboard checks every cycle) ----------------
    for (int r = 0; r < 300; r++) begin
      int len;
      set_pin(1'($urandom_range(0, 1)));
      enable = ($urandom_range(0, 9) != 0);
      len    = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        irq_ack     = ($urandom_range(0, 7) == 0);
        count_clear = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1; tick(1); rst = 1'b0;
        end else begin
          tick(1);
        end
      end
    end
    irq_ack = 1'b0; count_clear = 1'b0;
    tick(2);
    chk("end_top_t", 32'(top_t), 32'hF);
    chk("end_bot_o", 32'(bot_o), 32'h0);

    sb_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
